packet_dispatcher_n: RTL and testbench
======================================

Name: packet_dispatcher_n

Overview:
- Next-generation column-0 dispatcher: one AXI-stream packet input is distributed to NUM_PORTS tile-facing AXI-stream outputs.
- Routing is packet-atomic: a packet is never split across ports.
- Selection mode is set by parameter: round-robin, first-ready rotating priority, or header-directed.
- Adds a per-port enable mask, a drop path for unroutable packets, and saturating per-port packet counters for bring-up visibility.

Parameters:
- NUM_PORTS, 4, number of output ports (2..16).
- BW, 32, TDATA width in bits.
- BWB, BW/8, TKEEP width.
- MODE, 0, routing mode: 0 = round-robin, 1 = first-ready, 2 = header-directed.
- DEST_LSB, 0, LSB of the destination field in the first beat's TDATA (MODE 2 only).
- DEST_W, $clog2(NUM_PORTS), destination field width.
- CNT_W, 16, counter width.

Ports:
- clk_line  in  1  line clock; the only clock.
- clk_line_rst_low  in  1  asynchronous active-low reset.
- stream_in_packet_TVALID  in  1  input valid.
- stream_in_packet_TDATA  in  BW  input data.
- stream_in_packet_TKEEP  in  BWB  input keep.
- stream_in_packet_TLAST  in  1  input last.
- stream_in_packet_TREADY  out  1  input ready.
- stream_out_packet_TVALID  out  NUM_PORTS  per-port valid.
- stream_out_packet_TDATA  out  NUM_PORTS*BW  per-port data; port i occupies bits [i*BW +: BW].
- stream_out_packet_TKEEP  out  NUM_PORTS*BWB  per-port keep.
- stream_out_packet_TLAST  out  NUM_PORTS  per-port last.
- stream_out_packet_TREADY  in  NUM_PORTS  per-port ready.
- port_enable  in  NUM_PORTS  1 = port eligible for new packets.
- pkt_count  out  NUM_PORTS*CNT_W  packets delivered per port.
- drop_count  out  CNT_W  packets discarded.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, sel = 0, rr_ptr = 0, all counters 0.
  - All TVALID, TLAST and TREADY outputs 0; TDATA and TKEEP 0.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - stream_in_packet_TREADY = 0.
  - When TVALID = 1, compute the target from the first beat, register it into sel, and move to FWD (or DROP) on the next edge. The beat is not consumed in IDLE.
  - Cost: one bubble cycle per packet.
- Target selection:
  - MODE 0: first enabled port searching upward from rr_ptr with wrap. If no port is enabled, stay in IDLE (stall; nothing dropped).
  - MODE 1: first port with port_enable & TREADY, searching upward from rr_ptr with wrap. If none qualifies, stay in IDLE.
  - MODE 2: dest = TDATA[DEST_LSB +: DEST_W]. If dest >= NUM_PORTS or port_enable[dest] = 0, go to DROP; otherwise sel = dest. rr_ptr is unused.
  - MODE 0/1: on a selection, rr_ptr = sel + 1, wrapping to 0 after NUM_PORTS-1.
- FWD:
  - Combinational pass-through to port sel only.
  - out TVALID[sel] = in TVALID; in TREADY = out TREADY[sel]; data, keep and last are driven on slice sel.
  - Every other slice has TVALID = 0 and TLAST = 0.
  - On a handshake with TLAST = 1: pkt_count[sel]++ and return to IDLE.
- DROP:
  - in TREADY = 1; all out TVALID = 0.
  - On a handshake with TLAST = 1: drop_count++ and return to IDLE.
- Single-beat packets (TLAST on the first beat) take IDLE→FWD/DROP→IDLE, i.e. 2 cycles.
- port_enable changes only affect the next selection; a packet already locked completes on its port.
- Counters saturate at all-ones and never wrap.
- AXI rule: once asserted, out TVALID[sel] holds until the handshake; this follows from input-side AXI compliance because sel is fixed in FWD.
- Reset mid-packet: the packet is abandoned and outputs go to 0 immediately. Upstream is responsible for flushing.

Decomposition:
- dispatcher_pkg: mode localparams (MODE_RR, MODE_FIRST_RDY, MODE_HDR) and the state enum (IDLE, FWD, DROP).
- Sub-module rr_pick (parameter N): rotating-priority first-one finder. Inputs: request vector, start pointer. Outputs: index, found. Shared by MODE 0 and MODE 1.

Test Plan:
1. MODE 0, NUM_PORTS = 4, all enabled, all ready: send 8 single-beat packets → they land on ports 0,1,2,3,0,1,2,3; pkt_count = {2,2,2,2}; each packet takes 2 cycles.
2. MODE 0, port_enable = 4'b1010, send 4 packets of 3 beats → ports 1,3,1,3. Then set port_enable = 0 → in TREADY stays 0 and no TVALID asserts for 20 cycles.
3. MODE 1, TREADY = 4'b0100 → packet goes to port 2. Hold TREADY[2] = 0 mid-packet for 5 cycles → in TREADY = 0, beats are not duplicated or lost, TLAST is delivered on port 2.
4. MODE 2, DEST_LSB = 0: first beats 0x3, 0x1, 0x7 (dest ≥ 4), 0x2 with port 2 disabled → ports 3 and 1 receive their packets; the remaining two are dropped; drop_count = 2; no TVALID on any port during DROP.
5. CNT_W = 4: send 20 packets to port 0 → pkt_count[0] saturates at 15.
6. Assert clk_line_rst_low = 0 mid-packet in FWD → all outputs 0 in the same cycle (async). After release, state = IDLE and the next packet routes to port 0 (MODE 0).

Source files
------------

// File: rtl/packet_dispatcher_n_pkg.sv
// Shared mode encodings and FSM state type for the column-0 packet dispatcher.
package dispatcher_pkg;

  localparam int MODE_RR        = 0;
  localparam int MODE_FIRST_RDY = 1;
  localparam int MODE_HDR       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/packet_dispatcher_n_rr_pick.sv
// Rotating-priority first-one finder: lowest set request at or above start, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan N positions beginning at start; the first hit wins.
  always_comb begin
    int p;
    p     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = (int'(start) + k) % N;
      if (!found && req[p]) begin
        found = 1'b1;
        idx   = IW'(p);
      end
    end
  end

endmodule

// File: rtl/packet_dispatcher_n.sv
// One AXI-stream input fanned out packet-atomically to NUM_PORTS outputs,
// with enable mask, drop path and saturating per-port packet counters.
module packet_dispatcher_n
  import dispatcher_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int BW        = 32,
  parameter int BWB       = BW / 8,
  parameter int MODE      = MODE_RR,
  parameter int DEST_LSB  = 0,
  parameter int DEST_W    = $clog2(NUM_PORTS),
  parameter int CNT_W     = 16
) (
  input  logic                     clk_line,
  input  logic                     clk_line_rst_low,
  input  logic                     stream_in_packet_TVALID,
  input  logic [BW-1:0]            stream_in_packet_TDATA,
  input  logic [BWB-1:0]           stream_in_packet_TKEEP,
  input  logic                     stream_in_packet_TLAST,
  output logic                     stream_in_packet_TREADY,
  output logic [NUM_PORTS-1:0]     stream_out_packet_TVALID,
  output logic [NUM_PORTS*BW-1:0]  stream_out_packet_TDATA,
  output logic [NUM_PORTS*BWB-1:0] stream_out_packet_TKEEP,
  output logic [NUM_PORTS-1:0]     stream_out_packet_TLAST,
  input  logic [NUM_PORTS-1:0]     stream_out_packet_TREADY,
  input  logic [NUM_PORTS-1:0]     port_enable,
  output logic [NUM_PORTS*CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int SW = $clog2(NUM_PORTS);

  state_t                           state, state_nx;
  logic [SW-1:0]                    sel, sel_nx, rr_ptr, rr_nx;
  logic [SW-1:0]                    pick;
  logic                             found;
  logic [NUM_PORTS-1:0]             pick_req;
  logic [DEST_W-1:0]                dest;
  logic                             dest_ok;
  logic                             pkt_done, drop_done;
  logic [NUM_PORTS-1:0][BW-1:0]     odata;
  logic [NUM_PORTS-1:0][BWB-1:0]    okeep;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]                 drops;

  // First-ready mode only considers ports that can take the first beat right now.
  assign pick_req = (MODE == MODE_FIRST_RDY) ? (port_enable & stream_out_packet_TREADY)
                                             : port_enable;

  rr_pick #(.N(NUM_PORTS), .IW(SW)) u_pick (
    .req   (pick_req),
    .start (rr_ptr),
    .idx   (pick),
    .found (found)
  );

  assign dest = stream_in_packet_TDATA[DEST_LSB +: DEST_W];

  // Header destination is routable only if in range and that port is enabled.
  always_comb begin
    dest_ok = 1'b0;
    if ({1'b0, dest} < (DEST_W+1)'(NUM_PORTS))
      dest_ok = port_enable[SW'(dest)];
  end

  // Next-state, selection and the combinational pass-through datapath.
  always_comb begin
    state_nx                 = state;
    sel_nx                   = sel;
    rr_nx                    = rr_ptr;
    pkt_done                 = 1'b0;
    drop_done                = 1'b0;
    stream_in_packet_TREADY  = 1'b0;
    stream_out_packet_TVALID = '0;
    stream_out_packet_TLAST  = '0;
    odata                    = '0;
    okeep                    = '0;
    case (state)
      IDLE: begin
        // First beat is only inspected here; it is consumed in FWD/DROP.
        if (stream_in_packet_TVALID) begin
          if (MODE == MODE_HDR) begin
            if (dest_ok) begin
              state_nx = FWD;
              sel_nx   = SW'(dest);
            end else begin
              state_nx = DROP;
            end
          end else if (found) begin
            state_nx = FWD;
            sel_nx   = pick;
            rr_nx    = (pick == SW'(NUM_PORTS-1)) ? '0 : pick + 1'b1;
          end
        end
      end
      FWD: begin
        stream_in_packet_TREADY       = stream_out_packet_TREADY[sel];
        stream_out_packet_TVALID[sel] = stream_in_packet_TVALID;
        stream_out_packet_TLAST[sel]  = stream_in_packet_TLAST;
        odata[sel]                    = stream_in_packet_TDATA;
        okeep[sel]                    = stream_in_packet_TKEEP;
        if (stream_in_packet_TVALID && stream_out_packet_TREADY[sel] &&
            stream_in_packet_TLAST) begin
          pkt_done = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: begin
        stream_in_packet_TREADY = 1'b1;
        if (stream_in_packet_TVALID && stream_in_packet_TLAST) begin
          drop_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stream_out_packet_TDATA = odata;
  assign stream_out_packet_TKEEP = okeep;
  assign pkt_count               = cnt;
  assign drop_count              = drops;

  // State, locked port and rotation pointer.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      rr_ptr <= rr_nx;
    end
  end

  // Saturating delivery and drop counters.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      cnt   <= '0;
      drops <= '0;
    end else begin
      if (pkt_done && cnt[sel] != '1)
        cnt[sel] <= cnt[sel] + 1'b1;
      if (drop_done && drops != '1)
        drops <= drops + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_dispatcher_n.sv
// Scoreboard bench: three dispatchers (round-robin, first-ready, header) on one clock.
module tb_packet_dispatcher_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  tv = '0;
  logic [31:0] din = '0;
  logic [3:0]  dkeep = '0;
  logic        dlast = 1'b0;
  logic [2:0]  in_rdy;
  logic [3:0]  ov   [3];
  logic [127:0] od  [3];
  logic [15:0] okp  [3];
  logic [3:0]  ol   [3];
  logic [3:0]  ordy [3];
  logic [3:0]  en   [3];
  logic [15:0] pc0;
  logic [63:0] pc1, pc2;
  logic [3:0]  dc0;
  logic [15:0] dc1, dc2;
  logic [2:0]  quiet = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    int          k;
    int          port;
    logic [31:0] d;
    logic [3:0]  kp;
    logic        l;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  packet_dispatcher_n #(.NUM_PORTS(4), .BW(32), .MODE(0), .CNT_W(4)) u_rr (
    .clk_line(clk), .clk_line_rst_low(rst_n),
    .stream_in_packet_TVALID(tv[0]), .stream_in_packet_TDATA(din),
    .stream_in_packet_TKEEP(dkeep), .stream_in_packet_TLAST(dlast),
    .stream_in_packet_TREADY(in_rdy[0]),
    .stream_out_packet_TVALID(ov[0]), .stream_out_packet_TDATA(od[0]),
    .stream_out_packet_TKEEP(okp[0]), .stream_out_packet_TLAST(ol[0]),
    .stream_out_packet_TREADY(ordy[0]), .port_enable(en[0]),
    .pkt_count(pc0), .drop_count(dc0));

  packet_dispatcher_n #(.NUM_PORTS(4), .BW(32), .MODE(1)) u_fr (
    .clk_line(clk), .clk_line_rst_low(rst_n),
    .stream_in_packet_TVALID(tv[1]), .stream_in_packet_TDATA(din),
    .stream_in_packet_TKEEP(dkeep), .stream_in_packet_TLAST(dlast),
    .stream_in_packet_TREADY(in_rdy[1]),
    .stream_out_packet_TVALID(ov[1]), .stream_out_packet_TDATA(od[1]),
    .stream_out_packet_TKEEP(okp[1]), .stream_out_packet_TLAST(ol[1]),
    .stream_out_packet_TREADY(ordy[1]), .port_enable(en[1]),
    .pkt_count(pc1), .drop_count(dc1));

  // DEST_W widened to 3 so a header value of 7 is out of range for 4 ports.
  packet_dispatcher_n #(.NUM_PORTS(4), .BW(32), .MODE(2), .DEST_LSB(0), .DEST_W(3)) u_hdr (
    .clk_line(clk), .clk_line_rst_low(rst_n),
    .stream_in_packet_TVALID(tv[2]), .stream_in_packet_TDATA(din),
    .stream_in_packet_TKEEP(dkeep), .stream_in_packet_TLAST(dlast),
    .stream_in_packet_TREADY(in_rdy[2]),
    .stream_out_packet_TVALID(ov[2]), .stream_out_packet_TDATA(od[2]),
    .stream_out_packet_TKEEP(okp[2]), .stream_out_packet_TLAST(ol[2]),
    .stream_out_packet_TREADY(ordy[2]), .port_enable(en[2]),
    .pkt_count(pc2), .drop_count(dc2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (quiet[k]) begin
        n_cmp++;
        if (ov[k] !== 4'b0) begin
          n_err++;
          $display("FAIL quiet dut%0d: tvalid %b want 0000", k, ov[k]);
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (ov[k][p] && ordy[k][p]) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL hs dut%0d port%0d: unexpected beat d=%h", k, p, od[k][p*32 +: 32]);
          end else begin
            exp_t e;
            e = q.pop_front();
            if (e.k != k || e.port != p || od[k][p*32 +: 32] !== e.d ||
                okp[k][p*4 +: 4] !== e.kp || ol[k][p] !== e.l) begin
              n_err++;
              $display("FAIL hs: got dut%0d port%0d d=%h k=%h l=%b want dut%0d port%0d d=%h k=%h l=%b",
                       k, p, od[k][p*32 +: 32], okp[k][p*4 +: 4], ol[k][p],
                       e.k, e.port, e.d, e.kp, e.l);
            end
          end
        end
      end
    end
  end

  // Present one beat to dut k and hold it until the input handshake.
  task automatic send_beat(input int k, input logic [31:0] d, input logic l);
    int t;
    tv[k] = 1'b1; din = d; dkeep = d[7:4]; dlast = l;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_rdy[k]) break;
    end
    if (t == 50) begin
      n_cmp++; n_err++;
      $display("FAIL timeout dut%0d: tready never rose for d=%h", k, d);
    end
    @(posedge clk); #1;
    tv[k] = 1'b0; dlast = 1'b0;
  endtask

  task automatic send_pkt(input int k, input int port, input int nb,
                          input logic [31:0] base, input bit drop);
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      d = base + 32'(b * 16);
      if (!drop) q.push_back('{k: k, port: port, d: d, kp: d[7:4], l: (b == nb-1)});
      send_beat(k, d, b == nb-1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit bad;
    for (int k = 0; k < 3; k++) begin ordy[k] = 4'hF; en[k] = 4'hF; end
    // Reset: outputs must stay quiet even with traffic offered.
    tv = 3'b111; din = 32'hFFFF_FFFF; dlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst tvalid/tready dut%0d", k), {in_rdy[k], ov[k], ol[k]}, '0);
      chk($sformatf("rst data dut%0d", k), {od[k][63:0] | od[k][127:64], okp[k]}, '0);
    end
    chk("rst counters", {pc0, dc0, pc1, dc1, pc2[15:0], dc2}, '0);
    tv = '0; dlast = 1'b0; din = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin, 8 single-beat packets, 2 cycles each.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_pkt(0, i % 4, 1, 32'h1000_0000 + 32'(i << 8), 0);
    chk("rr cycles for 8 pkts", 64'(cyc - c0), 64'd16);
    chk("rr pkt_count", 64'(pc0), 64'h2222);

    // Sparse enable: ports 1,3 alternate with 3-beat packets.
    en[0] = 4'b1010;
    for (int i = 0; i < 4; i++) send_pkt(0, (i % 2) ? 3 : 1, 3, 32'h2000_0000 + 32'(i << 12), 0);
    chk("rr sparse pkt_count", 64'(pc0), 64'h4242);

    // Nothing enabled: stall with no acceptance and no output.
    en[0] = 4'b0000; tv[0] = 1'b1; din = 32'h2BAD_0000; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_rdy[0] || ov[0] != 0) bad = 1;
    end
    chk("rr all disabled stall", 64'(bad), 64'd0);
    @(posedge clk); #1;
    tv[0] = 1'b0;

    // Saturation: 20 more packets to port 0 with 4-bit counters.
    en[0] = 4'b0001;
    for (int i = 0; i < 20; i++) send_pkt(0, 0, 1, 32'h3000_0000 + 32'(i << 8), 0);
    chk("rr saturate pkt_count", 64'(pc0), 64'h424F);

    // First-ready: only port 2 ready, then stall it mid-packet.
    ordy[1] = 4'b0100;
    q.push_back('{k: 1, port: 2, d: 32'h4000_0000, kp: 4'h0, l: 1'b0});
    q.push_back('{k: 1, port: 2, d: 32'h4000_0010, kp: 4'h1, l: 1'b0});
    q.push_back('{k: 1, port: 2, d: 32'h4000_0020, kp: 4'h2, l: 1'b1});
    send_beat(1, 32'h4000_0000, 1'b0);
    ordy[1] = 4'b0000; tv[1] = 1'b1; din = 32'h4000_0010; dkeep = 4'h1; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_rdy[1] || ov[1] != 4'b0100) bad = 1;
    end
    chk("fr backpressure hold", 64'(bad), 64'd0);
    @(posedge clk); #1;
    ordy[1] = 4'b0100;
    send_beat(1, 32'h4000_0010, 1'b0);
    send_beat(1, 32'h4000_0020, 1'b1);
    ordy[1] = 4'b1111;
    send_pkt(1, 3, 1, 32'h4100_0000, 0);
    ordy[1] = 4'b0011;
    send_pkt(1, 0, 2, 32'h4200_0000, 0);
    chk("fr pkt_count", pc1, {16'd1, 16'd1, 16'd0, 16'd1});
    chk("fr drop_count", 64'(dc1), 64'd0);

    // Header-directed: 3,1 forwarded; 7 (range) and 2 (disabled) dropped.
    en[2] = 4'b1011;
    send_pkt(2, 3, 2, 32'h5000_0003, 0);
    send_pkt(2, 1, 2, 32'h5100_0001, 0);
    quiet[2] = 1'b1;
    send_pkt(2, 0, 2, 32'h5200_0007, 1);
    send_pkt(2, 0, 2, 32'h5300_0002, 1);
    quiet[2] = 1'b0;
    chk("hdr drop_count", 64'(dc2), 64'd2);
    chk("hdr pkt_count", pc2, {16'd1, 16'd0, 16'd1, 16'd0});

    // Reset mid-packet: rotation points at port 1, packet stalls on beat 2.
    en[0] = 4'b1111;
    q.push_back('{k: 0, port: 1, d: 32'h6000_0000, kp: 4'h0, l: 1'b0});
    send_beat(0, 32'h6000_0000, 1'b0);
    ordy[0] = 4'b0000; tv[0] = 1'b1; din = 32'h6000_0010; dkeep = 4'h1;
    #2;
    chk("pre-reset tvalid on port1", 64'(ov[0]), 64'b0010);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {in_rdy[0], ov[0], ol[0], od[0][63:0] | od[0][127:64], okp[0]}, '0);
    chk("async reset counters", {pc0, dc0}, '0);
    tv[0] = 1'b0;
    #3;
    rst_n = 1'b1;
    ordy[0] = 4'b1111;
    @(posedge clk); #1;
    send_pkt(0, 0, 1, 32'h7000_0000, 0);
    chk("post-reset route port0", 64'(pc0), 64'h0001);

    repeat (2) @(posedge clk);
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
